// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and counter-width helper for the button event front end
package btn_pkg;

    // Per-channel press tracking: released, pressed, pressed past the long-press limit
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_t;

    // Number of raw input samples the synchroniser delays before debouncing
    localparam int SYNC_STAGES = 2;

    // Width of a counter that must be able to hold the value 'limit'
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: polarity fix, 2-flop sync, debounce, press/release/long FSM (auto-repeat under BTN_AUTOREPEAT_EN)
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 1000000,
    parameter int LONG_CYCLES   = 100000000,
`ifdef BTN_AUTOREPEAT_EN
    parameter int REPEAT_CYCLES = 20000000,
`endif
    parameter bit PB_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W   = cnt_width(DB_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    // hold_cnt value one cycle before it reaches the limit; a one-cycle limit
    // fires on the first cycle after the press because hold_cnt enters at 0
    localparam logic [HOLD_W-1:0] HOLD_ARM  =
        (LONG_CYCLES >= 2) ? HOLD_W'(LONG_CYCLES - 2) : '0;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] r_rep_cnt;
`endif

    logic              w_pb_act;
    logic              w_accept;
    logic              r_s1;
    logic              r_s2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_held;
    logic [HOLD_W-1:0] r_hold_cnt;
    btn_state_t        r_state;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    assign w_pb_act = PB_ACTIVE_LOW ? ~pb : pb;
    // A level change is accepted on the cycle the mismatch run reaches DB_CYCLES
    assign w_accept = (r_s2 != r_held) && (r_db_cnt == DB_LAST);

    assign held          = r_held;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;

    // Two-flop synchroniser, loaded with the released level on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= w_pb_act;
            r_s2 <= r_s1;
        end
    end

    // Debounce: count consecutive mismatches, flip held when the run is long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_held   <= 1'b0;
        end else if (r_s2 == r_held) begin
            r_db_cnt <= '0;
        end else if (w_accept) begin
            r_db_cnt <= '0;
            r_held   <= ~r_held;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Channel FSM; pulses are registered so they line up with the held change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt  <= '0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_hold_cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
                    r_rep_cnt  <= '0;
`endif
                    if (w_accept) begin
                        r_state <= HELD;
                        r_press <= 1'b1;
                    end
                end
                HELD: begin
`ifdef BTN_AUTOREPEAT_EN
                    r_rep_cnt <= '0;
`endif
                    // A release landing on the limit cycle wins over long_pulse
                    if (w_accept) begin
                        r_state    <= IDLE;
                        r_release  <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HOLD_ARM) begin
                        r_state    <= LONG;
                        r_long     <= 1'b1;
                        r_hold_cnt <= HOLD_LAST;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (w_accept) begin
                        r_state    <= IDLE;
                        r_release  <= 1'b1;
                        r_hold_cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
                        r_rep_cnt  <= '0;
                    end else if (r_rep_cnt == REP_LAST) begin
                        r_rep_cnt  <= '0;
                        r_press    <= 1'b1;
                    end else begin
                        r_rep_cnt  <= r_rep_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_ctl.sv
// rtl/button_event_ctl.sv - NUM_BTN independent debounced button channels with event pulses (optional BTN_AUTOREPEAT_EN)
module button_event_ctl
    import btn_pkg::*;
#(
    parameter int NUM_BTN       = 5,
    parameter int DB_CYCLES     = 1000000,
    parameter int LONG_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 20000000,
    parameter bit PB_ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] pb,
    output logic [NUM_BTN-1:0] held,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic               any_press
);

    // Counters compare against limit-1, so zero limits are meaningless
    if (DB_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_event_ctl: cycle limits must be >= 1");
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
`ifdef BTN_AUTOREPEAT_EN
            .REPEAT_CYCLES (REPEAT_CYCLES),
`endif
            .PB_ACTIVE_LOW (PB_ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .pb            (pb[g]),
            .held          (held[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .long_pulse    (long_pulse[g])
        );
    end

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_event_ctl.sv
// tb/tb_button_event_ctl.sv - table-driven plus randomized model check of button_event_ctl
module tb_button_event_ctl;

    localparam int NB   = 5;
    localparam int DB   = 4;
    localparam int LG   = 20;
    localparam int RP   = 6;
    localparam int DEND = 320;
    localparam int REND = 3400;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] pb  = '0;
    logic [NB-1:0] held, press_pulse, release_pulse, long_pulse;
    logic          any_press;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_event_ctl #(
        .NUM_BTN       (NB),
        .DB_CYCLES     (DB),
        .LONG_CYCLES   (LG),
        .REPEAT_CYCLES (RP),
        .PB_ACTIVE_LOW (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pb            (pb),
        .held          (held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .any_press     (any_press)
    );

    // One record per edge of interest: optional input change applied after
    // that edge, and the pulses required to be visible after that edge.
    typedef struct {
        int            e;
        bit            drive;
        logic [NB-1:0] pb;
        logic          rst;
        logic [NB-1:0] x_press;
        logic [NB-1:0] x_rel;
        logic [NB-1:0] x_long;
    } vec_t;

    vec_t vq[$];

    logic [NB-1:0] xp [0:DEND];
    logic [NB-1:0] xr [0:DEND];
    logic [NB-1:0] xl [0:DEND];

    // Behavioural reference: event times derived from edge arithmetic
    logic [NB-1:0] m_d1, m_d2, m_held, m_press, m_rel, m_long;
    int            m_mis_start [NB];
    int            m_press_edge[NB];
    int            m_long_edge [NB];
    bit            m_long_done [NB];

    task automatic add_drv(input int e, input logic [NB-1:0] p, input logic r);
        vq.push_back('{e: e, drive: 1'b1, pb: p, rst: r, x_press: '0, x_rel: '0, x_long: '0});
    endtask

    task automatic add_exp(input int e, input logic [NB-1:0] xpr, input logic [NB-1:0] xre,
                           input logic [NB-1:0] xlo);
        vq.push_back('{e: e, drive: 1'b0, pb: '0, rst: 1'b0, x_press: xpr, x_rel: xre, x_long: xlo});
    endtask

    task automatic check(input string nm, input int e, input logic [NB-1:0] got,
                         input logic [NB-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%b exp=%b", nm, e, got, exp);
        end
    endtask

    // Advance the reference by one clock edge with the inputs seen at that edge
    task automatic model_step(input int e, input logic r, input logic [NB-1:0] p);
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (r) begin
            m_d1   = '0;
            m_d2   = '0;
            m_held = '0;
            for (int c = 0; c < NB; c++) begin
                m_mis_start[c] = -1;
                m_long_done[c] = 1'b0;
            end
            return;
        end
        for (int c = 0; c < NB; c++) begin
            if (m_d2[c] == m_held[c])
                m_mis_start[c] = -1;
            else if (m_mis_start[c] < 0)
                m_mis_start[c] = e;
            if (m_mis_start[c] >= 0 && (e - m_mis_start[c] + 1) >= DB) begin
                m_held[c]      = ~m_held[c];
                m_mis_start[c] = -1;
                if (m_held[c]) begin
                    m_press[c]      = 1'b1;
                    m_press_edge[c] = e;
                    m_long_done[c]  = 1'b0;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end else if (m_held[c]) begin
                if (!m_long_done[c] && (e - m_press_edge[c]) == LG - 1) begin
                    m_long[c]      = 1'b1;
                    m_long_done[c] = 1'b1;
                    m_long_edge[c] = e;
                end else if (AR && m_long_done[c] && e > m_long_edge[c] &&
                             ((e - m_long_edge[c]) % RP) == 0) begin
                    m_press[c] = 1'b1;
                end
            end
        end
        m_d2 = m_d1;
        m_d1 = p;
    endtask

    initial begin
        logic [NB-1:0] xh;
        int            rem [NB];
        int            pick;
        int            rst_left;

        // Directed timeline: ch0 long hold, glitch, bounce; ch4 short and
        // release-on-limit; ch1+ch3 together; ch2 reset while in LONG
        add_drv(2,   5'b00000, 1'b0);
        add_drv(10,  5'b00001, 1'b0);
        add_exp(16,  5'b00001, '0, '0);
        add_exp(35,  '0, '0, 5'b00001);
        add_exp(41,  AR ? 5'b00001 : 5'b00000, '0, '0);
        add_exp(47,  AR ? 5'b00001 : 5'b00000, '0, '0);
        add_drv(50,  5'b00000, 1'b0);
        add_exp(53,  AR ? 5'b00001 : 5'b00000, '0, '0);
        add_exp(56,  '0, 5'b00001, '0);
        add_drv(70,  5'b00001, 1'b0);
        add_drv(73,  5'b00000, 1'b0);
        add_drv(90,  5'b00001, 1'b0);
        add_drv(91,  5'b00000, 1'b0);
        add_drv(92,  5'b00001, 1'b0);
        add_exp(98,  5'b00001, '0, '0);
        add_drv(110, 5'b00000, 1'b0);
        add_exp(116, '0, 5'b00001, '0);
        add_drv(130, 5'b10000, 1'b0);
        add_exp(136, 5'b10000, '0, '0);
        add_drv(140, 5'b00000, 1'b0);
        add_exp(146, '0, 5'b10000, '0);
        add_drv(160, 5'b10000, 1'b0);
        add_exp(166, 5'b10000, '0, '0);
        add_drv(179, 5'b00000, 1'b0);
        add_exp(185, '0, 5'b10000, '0);
        add_drv(200, 5'b01010, 1'b0);
        add_exp(206, 5'b01010, '0, '0);
        add_drv(210, 5'b00000, 1'b0);
        add_exp(216, '0, 5'b01010, '0);
        add_drv(230, 5'b00100, 1'b0);
        add_exp(236, 5'b00100, '0, '0);
        add_exp(255, '0, '0, 5'b00100);
        add_drv(260, 5'b00100, 1'b1);
        add_drv(262, 5'b00100, 1'b0);
        add_exp(268, 5'b00100, '0, '0);
        add_exp(287, '0, '0, 5'b00100);
        add_exp(293, AR ? 5'b00100 : 5'b00000, '0, '0);
        add_exp(299, AR ? 5'b00100 : 5'b00000, '0, '0);
        add_drv(300, 5'b00000, 1'b0);
        add_exp(305, AR ? 5'b00100 : 5'b00000, '0, '0);
        add_exp(306, '0, 5'b00100, '0);

        for (int e = 0; e <= DEND; e++) begin
            xp[e] = '0;
            xr[e] = '0;
            xl[e] = '0;
        end
        foreach (vq[i]) begin
            xp[vq[i].e] = xp[vq[i].e] | vq[i].x_press;
            xr[vq[i].e] = xr[vq[i].e] | vq[i].x_rel;
            xl[vq[i].e] = xl[vq[i].e] | vq[i].x_long;
        end

        xh = '0;
        for (int e = 0; e <= DEND; e++) begin
            @(posedge clk);
            model_step(e, rst, pb);
            if (rst) xh = '0;
            xh = (xh | xp[e]) & ~xr[e];
            @(negedge clk);
            check("dir_held",    e, held,          xh);
            check("dir_press",   e, press_pulse,   xp[e]);
            check("dir_release", e, release_pulse, xr[e]);
            check("dir_long",    e, long_pulse,    xl[e]);
            check("dir_any",     e, {{(NB-1){1'b0}}, any_press}, {{(NB-1){1'b0}}, |xp[e]});
            foreach (vq[i]) begin
                if (vq[i].drive && vq[i].e == e) begin
                    pb  = vq[i].pb;
                    rst = vq[i].rst;
                end
            end
        end

        // Random phase: per-channel level runs of glitch, short and long lengths
        for (int c = 0; c < NB; c++) rem[c] = $urandom_range(1, 10);
        rst_left = 0;
        for (int e = DEND + 1; e <= REND; e++) begin
            @(posedge clk);
            model_step(e, rst, pb);
            @(negedge clk);
            check("rnd_held",    e, held,          m_held);
            check("rnd_press",   e, press_pulse,   m_press);
            check("rnd_release", e, release_pulse, m_rel);
            check("rnd_long",    e, long_pulse,    m_long);
            check("rnd_any",     e, {{(NB-1){1'b0}}, any_press}, {{(NB-1){1'b0}}, |m_press});
            for (int c = 0; c < NB; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    pb[c] = ~pb[c];
                    pick  = $urandom_range(0, 9);
                    if (pick < 3)      rem[c] = $urandom_range(1, 5);
                    else if (pick < 7) rem[c] = $urandom_range(5, 25);
                    else               rem[c] = $urandom_range(20, 45);
                end
            end
            if (rst_left > 0) begin
                rst_left--;
                rst = (rst_left > 0);
            end else if ($urandom_range(0, 399) == 0) begin
                rst      = 1'b1;
                rst_left = $urandom_range(1, 2);
            end else begin
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
